mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle control unit for the 16-bit TSC CPU; successor to the single-cycle decoder.
//  Sequences each instruction through IF/ID/EX/MEM/WB and stalls on the memory ready handshake.
//  Emits per-state datapath controls: PC write, IR latch, memory, register file, ALU and PC-source selects.
//  Sits between the shared instruction/data memory port and the multi-cycle datapath.
// PARAMETERS
//  WORD_SIZE   16  instruction/data width; opcode = inst[WORD_SIZE-1 -: 4], funct = inst[5:0]
//  NUM_INST_W  16  width of the retired-instruction counter (INST_COUNT_EN only)
// PORTS
//  clk          in   1          system clock, rising edge
//  reset_n      in   1          asynchronous, active-low reset
//  inst         in   WORD_SIZE  IR contents (stable from ID until next IF)
//  mem_ready    in   1          memory access complete this cycle
//  bcond        in   1          branch condition from ALU compare
//  mem_read     out  1          memory read request
//  mem_write    out  1          memory write request
//  i_or_d       out  1          0 = PC address, 1 = ALU-out address
//  ir_write     out  1          latch memory data into IR
//  pc_write     out  1          unconditional PC update
//  pc_write_c   out  1          PC update qualified by bcond
//  pc_source    out  2          0 = PC+1, 1 = branch target, 2 = jump target, 3 = rs
//  alu_src_b    out  2          0 = rt, 1 = sign-extended imm, 2 = zero-extended imm, 3 = const 1
//  reg_dest     out  2          0 = rt, 1 = rd, 2 = $2
//  reg_write    out  1          register file write enable
//  mem_to_reg   out  1          write-back source is MDR
//  reg2save     out  1          write-back source is PC (JAL/JRL)
//  wwd          out  1          one-cycle output-port strobe
//  is_halted    out  1          HLT executed
//  num_inst     out  NUM_INST_W retired count (INST_COUNT_EN only)
// BEHAVIOUR
//  States: IF, ID, EX, MEM, WB, HALT. reset_n low -> state IF asynchronously; every output 0 while low.
//  Outputs are Moore-decoded from state + inst; defaults 0.
//  IF: mem_read=1, i_or_d=0. While mem_ready=0 -> stay.
//    mem_ready=1 -> ir_write=1, pc_write=1, pc_source=0 (PC+1) -> ID.
//  ID: HLT (15/29) -> HALT. WWD (15/28) -> wwd=1, -> IF.
//    Undefined opcode 11-14 or undefined funct -> IF as NOP (no writes). All others -> EX.
//  EX:
//    R-ALU (15/0-7) -> WB.
//    ADI/LHI (4,6): alu_src_b=1 -> WB.
//    ORI (5): alu_src_b=2 -> WB.
//    LWD/SWD (7,8): alu_src_b=1 -> MEM.
//    BNE/BEQ/BGZ/BLZ (0-3): pc_write_c=1, pc_source=1 -> IF.
//    JMP (9): pc_write=1, pc_source=2 -> IF.
//    JAL (10): pc_write=1, pc_source=2 -> WB.
//    JPR (15/25): pc_write=1, pc_source=3 -> IF.
//    JRL (15/26): pc_write=1, pc_source=3 -> WB.
//  MEM: i_or_d=1; mem_read=1 (LWD) or mem_write=1 (SWD), held until mem_ready.
//    On mem_ready: LWD -> WB, SWD -> IF.
//  WB: reg_write=1. Destination/source per instruction:
//    R-ALU: reg_dest=1. I-type: reg_dest=0. LWD: mem_to_reg=1.
//    JAL/JRL: reg_dest=2, reg2save=1. Then -> IF.
//  HALT: absorbing; is_halted=1, no memory requests; exits only via reset_n.
//  Latency: branch/jump 3 cycles, ALU 4, SWD 4, LWD 5, each plus memory wait cycles.
//  Reset mid-MEM: request drops immediately; after release, fetch restarts in IF.
// CONFIGURATION
//  INST_COUNT_EN defined: num_inst resets to 0.
//    +1 on every retire (any ->IF transition out of ID/EX/MEM/WB, and entry into HALT); wraps modulo 2^NUM_INST_W.
//  INST_COUNT_EN undefined: num_inst port and counter are absent.
// TESTING
//  1. Reset, ADD $3=$1+$2, mem_ready=1 in 1st IF cycle -> IF,ID,EX,WB; reg_write=1, reg_dest=1 only in WB; num_inst=1.
//  2. LWD with mem_ready low 3 cycles in MEM -> mem_read=1, i_or_d=1 for 4 cycles; WB mem_to_reg=1.
//  3. BEQ with bcond=1, then bcond=0 -> pc_write_c=1, pc_source=1 in EX; back to IF after 3 cycles; no reg_write.
//  4. JAL -> EX pc_write=1, pc_source=2; WB reg_dest=2, reg2save=1; JRL -> pc_source=3, same WB.
//  5. HLT -> is_halted=1 next cycle, mem_read stays 0 for 10 cycles; reset_n low mid-MEM -> outputs 0 at once, IF after release.
//  6. Opcode 15 funct 63, then opcode 12 -> ID->IF, no write strobes; num_inst +1 each.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB control unit for the 16-bit TSC CPU.
// Define INST_COUNT_EN to add the retired-instruction counter output num_inst.
module mc_control_fsm #(
   parameter int unsigned WORD_SIZE  = 16,
   parameter int unsigned NUM_INST_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] inst,
   input  logic                 mem_ready,
   input  logic                 bcond,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 i_or_d,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_write_c,
   output logic [1:0]           pc_source,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           reg_dest,
   output logic                 reg_write,
   output logic                 mem_to_reg,
   output logic                 reg2save,
   output logic                 wwd,
   output logic                 is_halted
`ifdef INST_COUNT_EN
   ,
   output logic [NUM_INST_W-1:0] num_inst
`endif
);

   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

   state_t r_state;
   state_t w_next;

   logic [3:0] w_op;
   logic [5:0] w_funct;
   logic w_rtype, w_r_alu, w_jpr, w_jrl, w_wwd, w_hlt;
   logic w_branch, w_adi_lhi, w_ori, w_lwd, w_swd, w_jmp, w_jal, w_valid;

   assign w_op      = inst[WORD_SIZE-1 -: 4];
   assign w_funct   = inst[5:0];
   assign w_rtype   = (w_op == 4'd15);
   assign w_r_alu   = w_rtype && (w_funct <= 6'd7);
   assign w_jpr     = w_rtype && (w_funct == 6'd25);
   assign w_jrl     = w_rtype && (w_funct == 6'd26);
   assign w_wwd     = w_rtype && (w_funct == 6'd28);
   assign w_hlt     = w_rtype && (w_funct == 6'd29);
   assign w_branch  = (w_op <= 4'd3);
   assign w_adi_lhi = (w_op == 4'd4) || (w_op == 4'd6);
   assign w_ori     = (w_op == 4'd5);
   assign w_lwd     = (w_op == 4'd7);
   assign w_swd     = (w_op == 4'd8);
   assign w_jmp     = (w_op == 4'd9);
   assign w_jal     = (w_op == 4'd10);
   assign w_valid   = w_branch | w_adi_lhi | w_ori | w_lwd | w_swd | w_jmp | w_jal
                    | w_r_alu | w_jpr | w_jrl;

   // Register fields and bcond are consumed by the datapath, not by sequencing.
   logic w_unused_bits;
   assign w_unused_bits = ^{inst[WORD_SIZE-5:6], bcond};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IF;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_write_c = 1'b0;
      pc_source  = 2'd0;
      alu_src_b  = 2'd0;
      reg_dest   = 2'd0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg2save   = 1'b0;
      wwd        = 1'b0;
      is_halted  = 1'b0;
      case (r_state)
         S_IF: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               w_next   = S_ID;
            end
         end
         S_ID: begin
            if (w_hlt)        w_next = S_HALT;
            else if (w_wwd) begin
               wwd    = 1'b1;
               w_next = S_IF;
            end
            else if (w_valid) w_next = S_EX;
            else              w_next = S_IF;
         end
         S_EX: begin
            w_next = S_IF;
            if (w_r_alu)                  w_next = S_WB;
            else if (w_adi_lhi) begin
               alu_src_b = 2'd1;
               w_next    = S_WB;
            end
            else if (w_ori) begin
               alu_src_b = 2'd2;
               w_next    = S_WB;
            end
            else if (w_lwd || w_swd) begin
               alu_src_b = 2'd1;
               w_next    = S_MEM;
            end
            else if (w_branch) begin
               pc_write_c = 1'b1;
               pc_source  = 2'd1;
            end
            else if (w_jmp || w_jal) begin
               pc_write  = 1'b1;
               pc_source = 2'd2;
               if (w_jal) w_next = S_WB;
            end
            else if (w_jpr || w_jrl) begin
               pc_write  = 1'b1;
               pc_source = 2'd3;
               if (w_jrl) w_next = S_WB;
            end
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = w_lwd;
            mem_write = w_swd;
            if (mem_ready) w_next = w_lwd ? S_WB : S_IF;
         end
         S_WB: begin
            reg_write = 1'b1;
            w_next    = S_IF;
            if (w_r_alu)               reg_dest = 2'd1;
            else if (w_lwd)            mem_to_reg = 1'b1;
            else if (w_jal || w_jrl) begin
               reg_dest = 2'd2;
               reg2save = 1'b1;
            end
         end
         S_HALT: is_halted = 1'b1;
         default: w_next = S_IF;
      endcase
      // Reset masks outputs combinationally so an in-flight request drops at once.
      if (!reset_n) begin
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         i_or_d     = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_write_c = 1'b0;
         pc_source  = 2'd0;
         alu_src_b  = 2'd0;
         reg_dest   = 2'd0;
         reg_write  = 1'b0;
         mem_to_reg = 1'b0;
         reg2save   = 1'b0;
         wwd        = 1'b0;
         is_halted  = 1'b0;
      end
   end

`ifdef INST_COUNT_EN
   logic w_retire;
   assign w_retire = ((w_next == S_IF) && (r_state != S_IF) && (r_state != S_HALT))
                   || ((w_next == S_HALT) && (r_state != S_HALT));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      num_inst <= '0;
      else if (w_retire) num_inst <= num_inst + 1'b1;
   end
`else
   localparam int unsigned UNUSED_CNT_W = NUM_INST_W;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: per-instruction expected output traces
// built from the instruction-class rules, compared every cycle.
module tb_mc_control_fsm;

   localparam int unsigned CW = 4;

   localparam logic [16:0] MR   = 17'h10000;
   localparam logic [16:0] MW   = 17'h08000;
   localparam logic [16:0] IOD  = 17'h04000;
   localparam logic [16:0] IRW  = 17'h02000;
   localparam logic [16:0] PCW  = 17'h01000;
   localparam logic [16:0] PCWC = 17'h00800;
   localparam logic [16:0] RW   = 17'h00010;
   localparam logic [16:0] M2R  = 17'h00008;
   localparam logic [16:0] R2S  = 17'h00004;
   localparam logic [16:0] WWDM = 17'h00002;
   localparam logic [16:0] HLTM = 17'h00001;

   function automatic logic [16:0] pcs(input int unsigned n); return 17'(n) << 9; endfunction
   function automatic logic [16:0] asb(input int unsigned n); return 17'(n) << 7; endfunction
   function automatic logic [16:0] rdm(input int unsigned n); return 17'(n) << 5; endfunction

   logic clk = 1'b0;
   logic reset_n;
   logic [15:0] inst;
   logic mem_ready, bcond;
   logic mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_c;
   logic [1:0] pc_source, alu_src_b, reg_dest;
   logic reg_write, mem_to_reg, reg2save, wwd, is_halted;
`ifdef INST_COUNT_EN
   logic [CW-1:0] num_inst;
`endif

   mc_control_fsm #(.WORD_SIZE(16), .NUM_INST_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .inst(inst), .mem_ready(mem_ready), .bcond(bcond),
      .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_c(pc_write_c), .pc_source(pc_source),
      .alu_src_b(alu_src_b), .reg_dest(reg_dest), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .reg2save(reg2save), .wwd(wwd), .is_halted(is_halted)
`ifdef INST_COUNT_EN
      , .num_inst(num_inst)
`endif
   );

   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned errs    = 0;
   int unsigned retired = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [16:0] outs();
      return {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_c, pc_source,
              alu_src_b, reg_dest, reg_write, mem_to_reg, reg2save, wwd, is_halted};
   endfunction

   task automatic check_count(input string tag);
`ifdef INST_COUNT_EN
      check(tag, 32'(num_inst), retired % (1 << CW));
`else
      check(tag, 32'(outs() & 17'h0), 32'h0);
`endif
   endtask

   // Builds the cycle-by-cycle expected trace from the instruction class, then plays it.
   task automatic run_inst(input logic [15:0] ins, input int unsigned if_wait,
                           input int unsigned mem_wait, input logic bc, input bit abort_mem);
      logic [16:0] exp_q[$];
      bit          rdy_q[$];
      int          mem_idx = -1;
      logic [3:0]  op = ins[15:12];
      logic [5:0]  fn = ins[5:0];
      bit          rt = (op == 4'd15);
      bit          is_alu = rt && fn <= 6'd7;
      bit          is_jpr = rt && fn == 6'd25, is_jrl = rt && fn == 6'd26;
      bit          is_wwd = rt && fn == 6'd28, is_hlt = rt && fn == 6'd29;
      for (int unsigned w = 0; w < if_wait; w++) begin exp_q.push_back(MR); rdy_q.push_back(1'b0); end
      exp_q.push_back(MR | IRW | PCW); rdy_q.push_back(1'b1);
      exp_q.push_back(is_wwd ? WWDM : 17'h0); rdy_q.push_back(1'($urandom_range(0, 1)));
      if (is_alu) begin
         exp_q.push_back(17'h0); exp_q.push_back(RW | rdm(1));
      end else if (op == 4'd4 || op == 4'd6) begin
         exp_q.push_back(asb(1)); exp_q.push_back(RW);
      end else if (op == 4'd5) begin
         exp_q.push_back(asb(2)); exp_q.push_back(RW);
      end else if (op == 4'd7 || op == 4'd8) begin
         exp_q.push_back(asb(1));
         rdy_q.push_back(1'($urandom_range(0, 1)));
         mem_idx = exp_q.size();
         for (int unsigned w = 0; w <= mem_wait; w++) begin
            exp_q.push_back(IOD | ((op == 4'd7) ? MR : MW));
            rdy_q.push_back(w == mem_wait);
         end
         if (op == 4'd7) exp_q.push_back(RW | M2R);
      end else if (op <= 4'd3) begin
         exp_q.push_back(PCWC | pcs(1));
      end else if (op == 4'd9 || op == 4'd10) begin
         exp_q.push_back(PCW | pcs(2));
         if (op == 4'd10) exp_q.push_back(RW | rdm(2) | R2S);
      end else if (is_jpr || is_jrl) begin
         exp_q.push_back(PCW | pcs(3));
         if (is_jrl) exp_q.push_back(RW | rdm(2) | R2S);
      end
      while (rdy_q.size() < exp_q.size()) rdy_q.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < exp_q.size(); i++) begin
         inst = ins; mem_ready = rdy_q[i]; bcond = bc;
         @(negedge clk);
         check($sformatf("op%0d_f%0d_c%0d", op, fn, i), 32'(outs()), 32'(exp_q[i]));
         if (abort_mem && i == mem_idx) begin
            reset_n = 1'b0;
            #1;
            check("rst_mid_mem_outs", 32'(outs()), 32'h0);
            retired = 0;
            check_count("rst_mid_mem_cnt");
            @(posedge clk); #1;
            reset_n = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
      retired++;
      check_count($sformatf("count_op%0d", op));
      if (is_hlt) begin
         for (int k = 0; k < 10; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("halted", 32'(outs()), 32'(HLTM));
            @(posedge clk); #1;
         end
         check_count("count_halt_stable");
      end
   endtask

   function automatic logic [15:0] rand_inst();
      logic [15:0] r = 16'($urandom);
      logic [5:0]  defs[11] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd25, 6'd26, 6'd28};
      if (r[15:12] == 4'd15 && $urandom_range(0, 1) == 1) r[5:0] = defs[$urandom_range(0, 10)];
      if (r[15:12] == 4'd15 && r[5:0] == 6'd29) r[5:0] = 6'd28;
      return r;
   endfunction

   initial begin
      reset_n = 1'b0; inst = 16'h0; mem_ready = 1'b0; bcond = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outs", 32'(outs()), 32'h0);
      check_count("reset_count");
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_inst(16'hF6C0, 0, 0, 1'b0, 1'b0);            // ADD $3=$1+$2
      run_inst(16'h7104, 1, 3, 1'b0, 1'b0);            // LWD, 3 wait cycles in MEM
      run_inst(16'h8104, 2, 1, 1'b0, 1'b0);            // SWD
      run_inst(16'h1203, 0, 0, 1'b1, 1'b0);            // BEQ taken
      run_inst(16'h1203, 0, 0, 1'b0, 1'b0);            // BEQ not taken
      run_inst(16'hA010, 0, 0, 1'b0, 1'b0);            // JAL
      run_inst(16'hF01A, 1, 0, 1'b0, 1'b0);            // JRL
      run_inst(16'hF019, 0, 0, 1'b0, 1'b0);            // JPR
      run_inst(16'h9020, 0, 0, 1'b0, 1'b0);            // JMP
      run_inst(16'hF01C, 0, 0, 1'b0, 1'b0);            // WWD
      run_inst(16'hF03F, 0, 0, 1'b0, 1'b0);            // undefined funct
      run_inst(16'hC000, 0, 0, 1'b0, 1'b0);            // undefined opcode
      run_inst(16'h4105, 0, 0, 1'b0, 1'b0);            // ADI
      run_inst(16'h5105, 0, 0, 1'b0, 1'b0);            // ORI
      run_inst(16'h6105, 0, 0, 1'b0, 1'b0);            // LHI

      for (int n = 0; n < 300; n++)
         run_inst(rand_inst(), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'b0);

      run_inst(16'hF01D, 0, 0, 1'b0, 1'b0);            // HLT
      reset_n = 1'b0;
      #1;
      check("halt_reset_outs", 32'(outs()), 32'h0);
      retired = 0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      check_count("halt_reset_count");

      run_inst(16'h7104, 0, 2, 1'b0, 1'b1);            // LWD aborted by reset in MEM
      run_inst(16'hF6C0, 1, 0, 1'b0, 1'b0);
      run_inst(16'h7104, 0, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
